// File: rtl/alu_serial_sequencer_if.sv
// rtl/alu_serial_sequencer_if.sv - request/response bundle for the bit-serial ALU sequencer
interface alu_serial_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [2:0]       aluOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output start, aluOp, A, B,
        input  busy, done, error, result, negative, zero, carry, overflow
    );

    modport slave (
        input  start, aluOp, A, B,
        output busy, done, error, result, negative, zero, carry, overflow
    );
endinterface

// File: rtl/alu_serial_sequencer.sv
// rtl/alu_serial_sequencer.sv - one-bit ALU slice plus a sequencer that runs it LSB-first over WIDTH cycles
module aluBit (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] aluOp,
    output logic       out,
    output logic       cout
);
    logic w_b_eff;

    // Subtract is a + ~b + 1; the +1 arrives through cin on bit 0.
    assign w_b_eff = aluOp[0] ? ~b : b;

    always_comb begin
        out  = 1'b0;
        cout = 1'b0;
        case (aluOp)
            3'b000: out = b;
            3'b010, 3'b011: begin
                out  = a ^ w_b_eff ^ cin;
                cout = (a & w_b_eff) | (cin & (a ^ w_b_eff));
            end
            3'b100: out = a & b;
            3'b101: out = a | b;
            3'b110: out = a ^ b;
            default: out = 1'b0;
        endcase
    end
endmodule

module alu_serial_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_serial_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_negative;
    logic             r_zero;
    logic             r_carry_flag;
    logic             r_overflow;

    logic             w_out;
    logic             w_cout;
    logic             w_op_valid;
    logic             w_arith;
    logic [WIDTH-1:0] w_next_result;

    aluBit u_slice (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .cin   (r_carry),
        .aluOp (r_op),
        .out   (w_out),
        .cout  (w_cout)
    );

    assign w_op_valid    = (bus.aluOp != 3'b001) && (bus.aluOp != 3'b111);
    assign w_arith       = (r_op[2:1] == 2'b01);
    assign w_next_result = {w_out, r_result[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_op         <= '0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_negative   <= 1'b0;
            r_zero       <= 1'b0;
            r_carry_flag <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= S_IDLE;
                    if (bus.start && w_op_valid) begin
                        r_a_sh  <= bus.A;
                        r_b_sh  <= bus.B;
                        r_op    <= bus.aluOp;
                        r_cnt   <= '0;
                        r_carry <= bus.aluOp[0];
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else if (bus.start) begin
                        // Illegal opcode: report immediately, slice untouched.
                        r_result     <= '0;
                        r_negative   <= 1'b0;
                        r_zero       <= 1'b0;
                        r_carry_flag <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_done       <= 1'b1;
                        r_error      <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_RUN: begin
                    r_result <= w_next_result;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        // On the MSB cycle r_carry still holds the carry into the MSB.
                        r_negative   <= w_out;
                        r_zero       <= (w_next_result == '0);
                        r_carry_flag <= w_arith & w_cout;
                        r_overflow   <= w_arith & (r_carry ^ w_cout);
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.error    = r_error;
    assign bus.result   = r_result;
    assign bus.negative = r_negative;
    assign bus.zero     = r_zero;
    assign bus.carry    = r_carry_flag;
    assign bus.overflow = r_overflow;
endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
Multi-cycle controller that computes a full-width ALU operation with a single instance of the team's one-bit ALU slice (aluBit), processing one bit per clock from LSB to MSB. It latches the operands, drives the slice's carry chain through a carry register and assembles the result in a shift register. It reports a start/busy/done handshake and NZCV-style flags to the surrounding datapath. It is the area-reduced alternative to the ripple ALU for the multi-cycle CPU variant.

Parameters:
WIDTH, 64, operand/result width in bits (legal range 2..64)
CNT_W, 7, counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
aluOp  input  3  operation: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
A  input  WIDTH  operand A, sampled with start
B  input  WIDTH  operand B, sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result and flags are valid
error  output  1  high with done when aluOp was 001 or 111
result  output  WIDTH  computed value, held until the next accepted start
negative  output  1  result[WIDTH-1]
zero  output  1  result == 0
carry  output  1  final carry-out (add/sub only, else 0)
overflow  output  1  signed overflow (add/sub only, else 0)

Behaviour:
- Reset (async, any state): state IDLE. busy, done, error, result, all flags, counter, shift registers and carry register go to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start with a valid aluOp: latch A, B and aluOp into internal registers, counter=0, carry reg=aluOp[0] (1 for sub, else 0), go to RUN.
- IDLE/DONE + start with aluOp 001 or 111: go to DONE directly, result=0, error=1, flags=0. The slice is never exercised.
- DONE without start: return to IDLE. done and error are high only while in DONE.
- RUN, each cycle:
  - The slice receives a=A_sh[0], b=B_sh[0], cin=carry reg, aluOp=latched op.
  - On the edge, the slice output shifts into result at the MSB (result <= {out, result[WIDTH-1:1]}).
  - A_sh and B_sh shift right, carry reg <= slice cout, counter++.
  - The carry into the MSB is captured when counter==WIDTH-1.
- RUN exit: after WIDTH RUN cycles (counter reaches WIDTH-1 and that bit is processed), go to DONE.
- Latency: start sampled at edge 0; done is high in the cycle after edge WIDTH, i.e. WIDTH+1 cycles after start.
- Back-to-back: a start seen in DONE is accepted and gives no IDLE bubble.
- start in RUN is ignored. Input changes during RUN have no effect.
- Flags are registered on entry to DONE and held with result:
  - carry = final cout for 010/011, else 0.
  - overflow = carry-into-MSB XOR final cout for 010/011, else 0.
  - negative = result MSB; zero = result == 0.
- result updates bit-by-bit during RUN. Consumers read it only when done is high or afterwards in IDLE.
- Reset mid-RUN: abandons the operation immediately; no done pulse is produced.

Test Plan:
- WIDTH=8, add, A=0x7F, B=0x01 -> done exactly 9 cycles after start; result=0x80, N=1, Z=0, C=0, V=1, busy high for 8 cycles.
- WIDTH=8, sub, A=0x05, B=0x05 -> result=0x00, Z=1, C=1, V=0. Then sub A=0x00, B=0x01 -> result=0xFF, N=1, C=0.
- WIDTH=8 logic ops: and 0xF0&0x3C -> 0x30; or -> 0xFC; xor 0xFF^0x0F -> 0xF0; pass B=0xA5 -> 0xA5. C=V=0 for all. Issue back-to-back with start held in DONE: no idle cycle between ops.
- aluOp=001 with start -> done+error one cycle after start, result=0. start pulsed during RUN of a valid add -> ignored, original result unchanged.
- Assert reset at RUN cycle 4 of a WIDTH=64 add -> all outputs 0 asynchronously, no done. Then add 0xFFFF_FFFF_FFFF_FFFF+1 -> result=0, Z=1, C=1, done after 65 cycles.
